pdp8_sram: RTL
==============

# pdp8_sram

Bridges the PDP-8 core's 15-bit-address, 12-bit-word memory request interface to the board's external asynchronous SRAM bank 1 (ram_a / ram1_io pins). It sits directly downstream of the CPU memory port, in place of the on-chip pdp8_ram, and sequences chip-enable, output-enable and write-enable strobes with configurable wait states. Completion is signalled by a one-cycle done pulse.

## Interface
- RD_WAIT, 2, cycles ram_oe_n/ram1_ce_n held low before read data is captured (minimum 1)
- WR_WAIT, 2, cycles ram_we_n held low per write (minimum 1)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- addr  in  15  word address (field + 12-bit address)
- data_in  in  12  write data
- data_out  out  12  last read data; registered
- rd  in  1  read request, level, sampled in IDLE
- wr  in  1  write request, level, sampled in IDLE
- done  out  1  one-cycle pulse: access complete
- parity_err  out  1  one-cycle pulse coincident with done on a read parity mismatch
- ram_a  out  18  SRAM address = {3'b000, addr}
- ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active low
- ram1_io  inout  16  SRAM data bus
- ram1_ce_n, ram1_ub_n, ram1_lb_n  out  1 each  chip/byte enables, active low

## Operation
- States: IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: all strobes high, ram1_io tri-stated. If wr=1, latch addr/data_in and go to WR_SETUP. Otherwise, if rd=1, latch addr and go to RD_ACCESS. wr has priority when both are high.
- RD_ACCESS (RD_WAIT cycles): ce_n, ub_n, lb_n and oe_n are 0; we_n is 1; bus is tri-stated. On the last cycle's edge, capture ram1_io[11:0] into data_out. Go to DONE.
- WR_SETUP (1 cycle): ce/ub/lb are 0; oe_n and we_n are 1; bus driven with {3'b000, p, data[11:0]}.
- WR_PULSE (WR_WAIT cycles): same as WR_SETUP, plus we_n=0.
- WR_HOLD (1 cycle): we_n=1; bus still driven; ce is 0.
- DONE (1 cycle): done=1; all strobes high; bus tri-stated. Next state is IDLE.
- Requests arriving outside IDLE are ignored. A request still held high in IDLE starts a new access, so the requester drops rd/wr on the done cycle.
- A wait-state counter sized to max(RD_WAIT, WR_WAIT) reloads on every state entry.
- data_out changes only on read capture. Writes leave it untouched.

## Timing
- Request sampled at edge N.
- Read: done is high in the cycle after edge N+RD_WAIT+1, so latency is RD_WAIT+1 edges to done. data_out is valid from the done cycle onward.
- Write: done is high after edge N+WR_WAIT+3.
- Idle-to-idle minimum periods: read is RD_WAIT+2 cycles; write is WR_WAIT+4 cycles.
- All outputs are registered; no combinational path from rd/wr to pins.
- Reset values: state=IDLE, ram_a=0, ce/ub/lb/oe/we_n=1, ram1_io=Z, data_out=0, done=0, parity_err=0.
- Reset mid-access: strobes return high and the bus goes to Z at that edge. No done is produced. The aborted write may be partial.
- Address and write data are stable from the first strobe assertion through WR_HOLD. Address changes only in IDLE.

## Configuration
- PDP8_SRAM_PARITY_EN defined:
  - Writes store bit 12 = odd parity of data[11:0] (p = ~^data).
  - Reads recompute parity and pulse parity_err with done if bit 12 mismatches.
  - data_out is still updated.
- PDP8_SRAM_PARITY_EN undefined:
  - Bit 12 is written 0 and ignored on read.
  - parity_err is constant 0.
  - The port is always present.

## Structure
- Package pdp8_sram_pkg holds:
  - state enumeration
  - SRAM_AW=18, CPU_AW=15, WORD_W=12
  - parity bit index constant
- Optional sub-module pdp8_sram_iobuf: tri-state driver with drive_en, out[15:0], in[15:0]. Keeps the inout isolated for synthesis/simulation swaps.
- Remainder is a single FSM plus counter.

## Test plan
- Write with defaults: wr with addr=15'o12345, data_in=12'o7070 → we_n low exactly 2 cycles, ram_a=18'o012345, bus=16'h0E38 (or 16'h1E38 with parity), done 5 edges after sample.
- Read-back: rd to the same address with the SRAM model → data_out=12'o7070, done 3 edges after sample, oe_n low exactly 2 cycles.
- rd=wr=1 simultaneously → write performed, no read strobe, one done.
- Reset asserted during WR_PULSE → we_n/ce_n high and bus Z at the next edge, no done, state IDLE.
- Parity (macro on): model flips bit 12 at 12'o0001 → read pulses parity_err with done; data_out=12'o0001. Macro off → parity_err stays 0.
- Back-to-back: rd held high through done → second access begins the cycle after DONE. Override with RD_WAIT=1, WR_WAIT=4 and check strobe widths.

Source files
------------

// File: rtl/pdp8_sram_pkg.sv
// Shared types and constants for the PDP-8 external SRAM bridge.
// Optional build macro: PDP8_SRAM_PARITY_EN (stores/checks odd parity in bus bit 12).
package pdp8_sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int CPU_AW  = 15;
    localparam int WORD_W  = 12;
    localparam int PAR_BIT = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACCESS = 3'd1,
        WR_SETUP  = 3'd2,
        WR_PULSE  = 3'd3,
        WR_HOLD   = 3'd4,
        DONE      = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [WORD_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/pdp8_sram_iobuf.sv
// Tri-state driver for the SRAM data bus, kept separate so the inout can be
// swapped for a vendor primitive without touching the sequencer.
module pdp8_sram_iobuf (
    input  logic        drive_en,
    input  logic [15:0] out,
    output logic [15:0] in,
    inout  wire  [15:0] io
);

    assign io = drive_en ? out : 16'hzzzz;
    assign in = io;

endmodule

// File: rtl/pdp8_sram.sv
// PDP-8 memory port to asynchronous SRAM bank 1 bridge with wait-state sequencing.
// Optional build macro: PDP8_SRAM_PARITY_EN (odd parity in bus bit 12, parity_err on reads).
module pdp8_sram
    import pdp8_sram_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addr,
    input  logic [11:0] data_in,
    output logic [11:0] data_out,
    input  logic        rd,
    input  logic        wr,
    output logic        done,
    output logic        parity_err,
    output logic [17:0] ram_a,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    inout  wire  [15:0] ram1_io,
    output logic        ram1_ce_n,
    output logic        ram1_ub_n,
    output logic        ram1_lb_n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              is_rd_r;
    logic              drive_r;
    logic [15:0]       wdata_r;
    logic [15:0]       bus_in_s;
    logic              wpar_s;
    logic              unused_s;

`ifdef PDP8_SRAM_PARITY_EN
    assign wpar_s = odd_parity(data_in);
`else
    assign wpar_s = 1'b0;
`endif

    assign unused_s = ^bus_in_s[15:12];

    pdp8_sram_iobuf u_iobuf (
        .drive_en (drive_r),
        .out      (wdata_r),
        .in       (bus_in_s),
        .io       (ram1_io)
    );

    // Sequencer: pins are registered from the current state, so they trail it by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            is_rd_r    <= 1'b0;
            drive_r    <= 1'b0;
            wdata_r    <= 16'h0000;
            ram_a      <= 18'd0;
            ram1_ce_n  <= 1'b1;
            ram1_ub_n  <= 1'b1;
            ram1_lb_n  <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            data_out   <= 12'd0;
            done       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            ram1_ce_n  <= !(state_r inside {RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD});
            ram1_ub_n  <= !(state_r inside {RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD});
            ram1_lb_n  <= !(state_r inside {RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD});
            ram_oe_n   <= !(state_r == RD_ACCESS);
            ram_we_n   <= !(state_r == WR_PULSE);
            drive_r    <= state_r inside {WR_SETUP, WR_PULSE, WR_HOLD};
            done       <= 1'b0;
            parity_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (wr) begin
                        ram_a   <= {3'b000, addr};
                        wdata_r <= {3'b000, wpar_s, data_in};
                        is_rd_r <= 1'b0;
                        state_r <= WR_SETUP;
                    end else if (rd) begin
                        ram_a   <= {3'b000, addr};
                        is_rd_r <= 1'b1;
                        cnt_r   <= RD_LOAD;
                        state_r <= RD_ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_ACCESS: begin
                    if (cnt_r == '0) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                WR_SETUP: begin
                    cnt_r   <= WR_LOAD;
                    state_r <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt_r == '0) begin
                        state_r <= WR_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    state_r <= DONE;
                end
                DONE: begin
                    // Read strobes are still low until this edge, so the bus holds valid data.
                    done    <= 1'b1;
                    state_r <= IDLE;
                    if (is_rd_r) begin
                        data_out <= bus_in_s[WORD_W-1:0];
`ifdef PDP8_SRAM_PARITY_EN
                        parity_err <= (bus_in_s[PAR_BIT] != odd_parity(bus_in_s[WORD_W-1:0]));
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
